pe_mac_os: RTL and testbench
============================

Name: pe_mac_os

Overview:
Parametrised next-generation systolic processing element. Adds per-operand valid qualifiers, signed/unsigned arithmetic and a wide accumulator. Supports two modes:
- CHAIN (mode=0): partial-sum pass-through, psum_out = psum_in + a*b.
- LOCAL (mode=1): output-stationary accumulation, followed by a drain sequence that emits the local result and then forwards upstream results down the column.

Instances tile into an R x C array. a flows east, b flows south, psums drain south.

Parameters:
DATA_W, 8, operand width of a and b
ACC_W, 24, accumulator and psum width; must be >= 2*DATA_W
SIGNED, 1, 1 = two's-complement operands and accumulator; 0 = unsigned
FWD_CNT, 0, number of upstream psum beats forwarded after own drain (equals row index)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
a_in  in  DATA_W  west operand
a_vld_in  in  1  a_in valid
b_in  in  DATA_W  north operand
b_vld_in  in  1  b_in valid
psum_in  in  ACC_W  upstream partial sum / drained result
psum_vld_in  in  1  psum_in valid
mode  in  1  0 = CHAIN, 1 = LOCAL; latched only while busy=0
clear  in  1  synchronous accumulator clear
drain  in  1  LOCAL mode: start drain sequence
a_out  out  DATA_W  registered a to east neighbour
a_vld_out  out  1  registered a_vld_in
b_out  out  DATA_W  registered b to south neighbour
b_vld_out  out  1  registered b_vld_in
psum_out  out  ACC_W  psum to south neighbour
psum_vld_out  out  1  psum_out valid, single-cycle per beat
busy  out  1  state != IDLE
ovf  out  1  sticky accumulator overflow flag

Behaviour:
- Reset (rst=0, async): all outputs 0; acc=0; state=IDLE; fwd counter=0; latched mode=0; ovf=0.
- Operand forwarding, 1-cycle latency:
  - a_vld_out <= a_vld_in, and a_out <= a_in only when a_vld_in=1 (otherwise held).
  - b_out and b_vld_out follow the same rule.
- fire = a_vld_in & b_vld_in.
- prod = a_in*b_in at 2*DATA_W bits, signed when SIGNED=1, then sign- or zero-extended to ACC_W.
- CHAIN mode:
  - psum_out <= (psum_vld_in ? psum_in : 0) + (fire ? prod : 0).
  - psum_vld_out <= fire | psum_vld_in.
  - Latency 1. State stays IDLE.
- LOCAL mode FSM, states IDLE, ACC, DRAIN, FWD:
  - IDLE -> ACC on fire (acc <= acc + prod).
  - ACC: each fire gives acc <= acc + prod.
  - IDLE/ACC -> DRAIN on drain=1.
  - The cycle after drain is sampled: psum_out = acc value, psum_vld_out = 1 for exactly one cycle. Draining from IDLE emits 0 with valid.
  - Acc reload on drain: on the drain-sampling edge, acc <= (fire ? prod : 0). If fire=1, a dirty flag is set.
  - DRAIN -> FWD if FWD_CNT > 0, otherwise DRAIN -> (dirty ? ACC : IDLE).
  - FWD: each psum_vld_in beat gives psum_out <= psum_in and psum_vld_out = 1, and the counter increments. When the counter reaches FWD_CNT, go to (dirty ? ACC : IDLE) and reset the counter.
  - FWD: fire keeps accumulating. Non-forward cycles have psum_vld_out = 0.
  - drain during DRAIN/FWD: ignored.
  - In LOCAL mode, psum_in is used only in FWD.
- clear: acc <= (fire ? prod : 0); ovf <= 0. clear has priority over accumulate but does not abort DRAIN/FWD. clear and drain together: the drained value is the pre-clear acc.
- Arithmetic: ACC_W two's-complement or unsigned wrap unless SAT_EN is defined.
- mode changes while busy=1 have no effect until IDLE.

Optional Feature:
PE_MAC_SAT_EN:
- Defined: every accumulate and CHAIN add saturates at the ACC_W limits. Signed limits are [-2^(ACC_W-1), 2^(ACC_W-1)-1]; unsigned limits are [0, 2^ACC_W-1]. Any saturation sets ovf=1 (sticky, cleared by clear or rst).
- Undefined: results wrap modulo 2^ACC_W; ovf is tied 0.

Test Plan:
1. CHAIN, DATA_W=8, ACC_W=24, SIGNED=1: a=3, b=-4, both valid, psum_in=100 valid -> next cycle psum_out=88, psum_vld_out=1, a_out=3, b_out=-4 (0xFC), busy=0.
2. LOCAL, FWD_CNT=2: pairs (2,3), (4,5), (-1,7), then drain -> psum_out=19 for one cycle. Then psum_in 11 and 22 (gapped by one idle cycle) are forwarded with valid. busy=0 the cycle after the 22 beat.
3. LOCAL, acc=10, drain asserted with fire (2,2) -> emits 10; state FWD and then ACC. A second drain emits 4.
4. Reset mid-FWD (after one forwarded beat): rst=0 -> all outputs 0 and busy=0 without a clock edge. After release, drain emits 0.
5. With PE_MAC_SAT_EN, ACC_W=16, SIGNED=1, LOCAL: 127*127 three times -> drained 32767, ovf=1. Without the macro: drained -17149, ovf=0.
6. a_vld_in=1, b_vld_in=0, a=9 -> a_out=9, a_vld_out=1, acc unchanged. Next cycle a_vld_in=0, a_in=5 -> a_out holds 9, a_vld_out=0.

Source files
------------

// File: rtl/pe_mac_os_if.sv
// pe_mac_os_if: operand, psum and control bundle of one systolic PE.
// slave = the PE side, master = whoever drives the PE.
interface pe_mac_os_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic [DATA_W-1:0] a_in;
  logic              a_vld_in;
  logic [DATA_W-1:0] b_in;
  logic              b_vld_in;
  logic [ACC_W-1:0]  psum_in;
  logic              psum_vld_in;
  logic              mode;
  logic              clear;
  logic              drain;
  logic [DATA_W-1:0] a_out;
  logic              a_vld_out;
  logic [DATA_W-1:0] b_out;
  logic              b_vld_out;
  logic [ACC_W-1:0]  psum_out;
  logic              psum_vld_out;
  logic              busy;
  logic              ovf;

  modport slave (
    input  a_in, a_vld_in, b_in, b_vld_in, psum_in, psum_vld_in, mode, clear, drain,
    output a_out, a_vld_out, b_out, b_vld_out, psum_out, psum_vld_out, busy, ovf
  );

  modport master (
    output a_in, a_vld_in, b_in, b_vld_in, psum_in, psum_vld_in, mode, clear, drain,
    input  a_out, a_vld_out, b_out, b_vld_out, psum_out, psum_vld_out, busy, ovf
  );
endinterface

// File: rtl/pe_mac_os.sv
// pe_mac_os: systolic MAC processing element.
//   mode=0 CHAIN : psum_out = psum_in + a*b, one cycle latency.
//   mode=1 LOCAL : output-stationary accumulate, then drain own result and
//                  forward FWD_CNT upstream results down the column.
// Optional macro PE_MAC_SAT_EN: saturating adds with sticky ovf; when
// undefined all adds wrap and ovf stays 0.
module pe_mac_os #(
  parameter int          DATA_W  = 8,
  parameter int          ACC_W   = 24,
  parameter int unsigned SIGNED  = 1,
  parameter int          FWD_CNT = 0
) (
  input  logic         clk,
  input  logic         rst,
  pe_mac_os_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, FWD} state_e;

  localparam int CNT_W = (FWD_CNT > 0) ? $clog2(FWD_CNT + 1) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [ACC_W-1:0]  psum_q, psum_d, acc_q, acc_d;
  logic              psum_vld_q, psum_vld_d;
  logic              ovf_q, ovf_d;
  logic              mode_q, mode_d;
  logic              dirty_q, dirty_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              fire;
  logic [2*DATA_W-1:0] prod_raw;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  acc_sum, chain_sum;
  logic              acc_ovf, chain_ovf;

  assign fire = bus.a_vld_in & bus.b_vld_in;

  // Full-precision product, then sign/zero extended to the accumulator width.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DATA_W-1:0] a_ext, b_ext;
      assign a_ext    = (2*DATA_W)'($signed(bus.a_in));
      assign b_ext    = (2*DATA_W)'($signed(bus.b_in));
      assign prod_raw = a_ext * b_ext;
      assign prod     = ACC_W'($signed(prod_raw));
    end else begin : g_unsigned
      assign prod_raw = (2*DATA_W)'(bus.a_in) * (2*DATA_W)'(bus.b_in);
      assign prod     = ACC_W'(prod_raw);
    end
  endgenerate

  // Returns {overflow, sum}; saturates only when the macro is set.
  function automatic logic [ACC_W:0] add_acc(input logic [ACC_W-1:0] x,
                                             input logic [ACC_W-1:0] y);
`ifdef PE_MAC_SAT_EN
    logic [ACC_W:0] s;
    if (SIGNED != 0) begin
      s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
      // Sign of the extended sum picks the rail: negative -> min, else max.
      if (s[ACC_W] != s[ACC_W-1])
        return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
      return {1'b0, s[ACC_W-1:0]};
    end else begin
      s = {1'b0, x} + {1'b0, y};
      if (s[ACC_W])
        return {1'b1, {ACC_W{1'b1}}};
      return {1'b0, s[ACC_W-1:0]};
    end
`else
    return {1'b0, x + y};
`endif
  endfunction

  assign {acc_ovf, acc_sum}     = add_acc(acc_q, prod);
  assign {chain_ovf, chain_sum} = add_acc(bus.psum_vld_in ? bus.psum_in : '0,
                                          fire ? prod : '0);

  // Next-state: operand pipes, chain add, LOCAL FSM, clear override.
  always_comb begin
    a_d        = bus.a_vld_in ? bus.a_in : a_q;
    a_vld_d    = bus.a_vld_in;
    b_d        = bus.b_vld_in ? bus.b_in : b_q;
    b_vld_d    = bus.b_vld_in;
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    dirty_d    = dirty_q;
    // Mode is live while idle and frozen once a LOCAL sequence is running.
    mode_d     = (state_q == IDLE) ? bus.mode : mode_q;

    if (!mode_d) begin
      psum_d     = chain_sum;
      psum_vld_d = fire | bus.psum_vld_in;
      ovf_d      = ovf_q | chain_ovf;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (bus.drain) begin
            psum_d     = acc_q;
            psum_vld_d = 1'b1;
            acc_d      = fire ? prod : '0;
            dirty_d    = fire;
            state_d    = DRAIN;
          end else if (fire) begin
            acc_d   = acc_sum;
            ovf_d   = ovf_q | acc_ovf;
            state_d = ACC;
          end
        end
        DRAIN: begin
          if (fire) begin
            acc_d   = acc_sum;
            ovf_d   = ovf_q | acc_ovf;
            dirty_d = 1'b1;
          end
          if (FWD_CNT > 0) begin
            state_d = FWD;
          end else begin
            state_d = dirty_d ? ACC : IDLE;
            dirty_d = 1'b0;
          end
        end
        FWD: begin
          if (fire) begin
            acc_d   = acc_sum;
            ovf_d   = ovf_q | acc_ovf;
            dirty_d = 1'b1;
          end
          if (bus.psum_vld_in) begin
            psum_d     = bus.psum_in;
            psum_vld_d = 1'b1;
            if (int'(cnt_q) + 1 >= FWD_CNT) begin
              cnt_d   = '0;
              state_d = dirty_d ? ACC : IDLE;
              dirty_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over accumulate but leaves drain/forward sequencing alone.
    if (bus.clear) begin
      acc_d = fire ? prod : '0;
      ovf_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      a_vld_q    <= 1'b0;
      b_q        <= '0;
      b_vld_q    <= 1'b0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      mode_q     <= 1'b0;
      dirty_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      a_vld_q    <= a_vld_d;
      b_q        <= b_d;
      b_vld_q    <= b_vld_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      mode_q     <= mode_d;
      dirty_q    <= dirty_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.a_out        = a_q;
  assign bus.a_vld_out    = a_vld_q;
  assign bus.b_out        = b_q;
  assign bus.b_vld_out    = b_vld_q;
  assign bus.psum_out     = psum_q;
  assign bus.psum_vld_out = psum_vld_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_pe_mac_os.sv
// tb_pe_mac_os: directed steps against two PEs:
//   u0: DATA_W=8, ACC_W=24, signed, FWD_CNT=2
//   u1: DATA_W=8, ACC_W=16, signed, FWD_CNT=0 (saturation/wrap case)
module tb_pe_mac_os;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pe_mac_os_if #(.DATA_W(8), .ACC_W(24)) bus0 ();
  pe_mac_os_if #(.DATA_W(8), .ACC_W(16)) bus1 ();

  pe_mac_os #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .FWD_CNT(2)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  pe_mac_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .FWD_CNT(0)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input int a, input bit av, input int b, input bit bv,
                      input int ps, input bit pv, input bit dr, input bit cl);
    bus0.a_in = 8'(a);  bus0.a_vld_in = av;
    bus0.b_in = 8'(b);  bus0.b_vld_in = bv;
    bus0.psum_in = 24'(ps); bus0.psum_vld_in = pv;
    bus0.drain = dr;    bus0.clear = cl;
  endtask

  task automatic drv1(input int a, input bit av, input int b, input bit bv,
                      input bit dr, input bit cl);
    bus1.a_in = 8'(a);  bus1.a_vld_in = av;
    bus1.b_in = 8'(b);  bus1.b_vld_in = bv;
    bus1.psum_in = '0;  bus1.psum_vld_in = 1'b0;
    bus1.drain = dr;    bus1.clear = cl;
  endtask

  function automatic logic [31:0] ps0();
    return 32'($signed(bus0.psum_out));
  endfunction

  initial begin
    bus0.mode = 1'b0; bus1.mode = 1'b0;
    drv0(0, 0, 0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_psum",     ps0(), 0);
    chk("rst_psum_vld", 32'(bus0.psum_vld_out), 0);
    chk("rst_busy",     32'(bus0.busy), 0);
    chk("rst_a_vld",    32'(bus0.a_vld_out), 0);
    chk("rst_ovf",      32'(bus1.ovf), 0);
    rst = 1'b1;

    // CHAIN: 100 + 3*(-4)
    drv0(3, 1, -4, 1, 100, 1, 0, 0);
    tick();
    chk("t1_psum",     ps0(), 88);
    chk("t1_psum_vld", 32'(bus0.psum_vld_out), 1);
    chk("t1_a_out",    32'(bus0.a_out), 3);
    chk("t1_b_out",    32'(bus0.b_out), 32'h0FC);
    chk("t1_busy",     32'(bus0.busy), 0);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_idle_vld", 32'(bus0.psum_vld_out), 0);

    // LOCAL accumulate 2*3 + 4*5 + (-1)*7 = 19, drain, forward 11 and 22
    bus0.mode = 1'b1;
    tick();
    drv0(2, 1, 3, 1, 0, 0, 0, 0);   tick();
    chk("t2_busy_acc", 32'(bus0.busy), 1);
    drv0(4, 1, 5, 1, 0, 0, 0, 0);   tick();
    drv0(-1, 1, 7, 1, 0, 0, 0, 0);  tick();
    chk("t2_no_emit", 32'(bus0.psum_vld_out), 0);
    drv0(0, 0, 0, 0, 0, 0, 1, 0);   tick();
    chk("t2_drain",     ps0(), 19);
    chk("t2_drain_vld", 32'(bus0.psum_vld_out), 1);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);   tick();
    chk("t2_one_cycle", 32'(bus0.psum_vld_out), 0);
    drv0(0, 0, 0, 0, 11, 1, 0, 0);  tick();
    chk("t2_fwd11",     ps0(), 11);
    chk("t2_fwd11_vld", 32'(bus0.psum_vld_out), 1);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);   tick();
    chk("t2_gap_vld",  32'(bus0.psum_vld_out), 0);
    chk("t2_gap_busy", 32'(bus0.busy), 1);
    drv0(0, 0, 0, 0, 22, 1, 0, 0);  tick();
    chk("t2_fwd22",      ps0(), 22);
    chk("t2_after_busy", 32'(bus0.busy), 0);

    // LOCAL: acc=10, drain with fire (2,2) reloads acc=4
    drv0(2, 1, 5, 1, 0, 0, 0, 0);   tick();
    drv0(2, 1, 2, 1, 0, 0, 1, 0);   tick();
    chk("t3_drain10", ps0(), 10);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);   tick();
    chk("t3_busy_fwd", 32'(bus0.busy), 1);
    drv0(0, 0, 0, 0, 5, 1, 0, 0);   tick();
    chk("t3_fwd5", ps0(), 5);
    drv0(0, 0, 0, 0, 6, 1, 0, 0);   tick();
    chk("t3_fwd6", ps0(), 6);
    chk("t3_busy_acc", 32'(bus0.busy), 1);
    drv0(0, 0, 0, 0, 0, 0, 1, 0);   tick();
    chk("t3_drain4",     ps0(), 4);
    chk("t3_drain4_vld", 32'(bus0.psum_vld_out), 1);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);   tick();
    drv0(0, 0, 0, 0, 1, 1, 0, 0);   tick();
    drv0(0, 0, 0, 0, 2, 1, 0, 0);   tick();
    chk("t3_idle", 32'(bus0.busy), 0);

    // Reset mid-FWD after one forwarded beat
    drv0(0, 0, 0, 0, 0, 0, 1, 0);   tick();
    chk("t4_drain0",     ps0(), 0);
    chk("t4_drain0_vld", 32'(bus0.psum_vld_out), 1);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);   tick();
    drv0(0, 0, 0, 0, 33, 1, 0, 0);  tick();
    chk("t4_fwd33", ps0(), 33);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    chk("t4_rst_psum", ps0(), 0);
    chk("t4_rst_vld",  32'(bus0.psum_vld_out), 0);
    chk("t4_rst_busy", 32'(bus0.busy), 0);
    rst = 1'b1;
    drv0(0, 0, 0, 0, 0, 0, 1, 0);   tick();
    chk("t4_post_drain",     ps0(), 0);
    chk("t4_post_drain_vld", 32'(bus0.psum_vld_out), 1);
    drv0(0, 0, 0, 0, 0, 0, 0, 0);   tick();
    rst = 1'b0; #2; rst = 1'b1;

    // Operand forwarding without fire, then clear with fire
    drv0(9, 1, 0, 0, 0, 0, 0, 0);   tick();
    chk("t6_a_out",   32'(bus0.a_out), 9);
    chk("t6_a_vld",   32'(bus0.a_vld_out), 1);
    chk("t6_no_fire", 32'(bus0.busy), 0);
    drv0(5, 0, 7, 1, 0, 0, 0, 0);   tick();
    chk("t6_a_hold",  32'(bus0.a_out), 9);
    chk("t6_a_vld0",  32'(bus0.a_vld_out), 0);
    chk("t6_b_out",   32'(bus0.b_out), 7);
    drv0(3, 1, 4, 1, 0, 0, 0, 0);   tick();
    drv0(1, 1, 1, 1, 0, 0, 0, 1);   tick();
    drv0(0, 0, 0, 0, 0, 0, 1, 0);   tick();
    chk("t6_clear_drain", ps0(), 1);

    // 127*127 three times into a 16-bit accumulator
    bus1.mode = 1'b1;
    drv1(127, 1, 127, 1, 0, 0);     tick();
    tick();
    tick();
    drv1(0, 0, 0, 0, 1, 0);         tick();
`ifdef PE_MAC_SAT_EN
    chk("t5_drain", 32'($signed(bus1.psum_out)), 32767);
    chk("t5_ovf",   32'(bus1.ovf), 1);
`else
    chk("t5_drain", 32'($signed(bus1.psum_out)), -17149);
    chk("t5_ovf",   32'(bus1.ovf), 0);
`endif
    chk("t5_drain_vld", 32'(bus1.psum_vld_out), 1);
    drv1(0, 0, 0, 0, 0, 0);         tick();
    chk("t5_idle", 32'(bus1.busy), 0);
    drv1(0, 0, 0, 0, 0, 1);         tick();
    chk("t5_clear_ovf", 32'(bus1.ovf), 0);
    drv1(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
